sum_latch_ctrl: RTL and testbench
=================================

Name: sum_latch_ctrl

Overview:
Operand-capture and transmit-request controller that sits directly upstream of the UART transmitter in the SumLatch datapath.
- Synchronises and debounces the two active-low save buttons.
- Latches operand A or B from the 3-bit data switches on each press.
- Computes A+B and issues one-byte send requests to the UART TX, handshaking on its busy flag.

Parameters:
DATA_W, 3, operand width; legal 1..7 so the sum fits in one byte.
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a press or release; legal ≥2.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
save_a_n  input  1  raw active-low button; press latches operand A.
save_b_n  input  1  raw active-low button; press latches operand B.
data_input  input  DATA_W  raw operand switches, sampled on an accepted press.
send_en  input  1  1 = requests may be issued; 0 = hold pending requests.
tx_busy  input  1  UART TX busy flag.
tx_start  output  1  one-cycle send strobe to the UART TX.
tx_data  output  8  byte to send: sum zero-extended.
sum_out  output  DATA_W+1  registered A+B.
a_valid  output  1  operand A has been latched since reset.
b_valid  output  1  operand B has been latched since reset.

Behaviour:
- Reset: clock and reset are as stated above (clk; reset asynchronous, active-high).
  - Synchroniser flops preset to 1 and debounced states to released.
  - Debounce counters, operand registers, sum_out, tx_data, a_valid, b_valid, tx_start and pending flag all reset to 0.
  - FSM resets to IDLE.
  - Reset asserted mid-operation aborts the request immediately; no strobe is emitted after release.
- Input conditioning:
  - Each button passes a 2-flop synchroniser.
  - A debounce counter increments while the synchronised level differs from the debounced state and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced state toggles and the counter clears.
  - The transition released→pressed produces a one-cycle press event.
  - Bounces shorter than DEBOUNCE_CYCLES produce no event.
- Capture:
  - On a press event, data_input (already 2-flop synchronised) loads into the operand register and sets the matching valid flag.
  - A and B events in the same cycle both capture the same data value.
  - Holding a button produces exactly one event.
- Arithmetic:
  - sum_out = A + B, unsigned, width DATA_W+1, no overflow.
  - Updated the cycle after any capture.
- Pending flag:
  - Set on the cycle sum_out updates while a_valid & b_valid.
  - Cleared when the FSM enters SEND.
  - A new capture during a transfer sets it again.
- FSM:
  - IDLE → SEND when pending & send_en & !tx_busy.
  - SEND (1 cycle): tx_start=1; tx_data={zeros, sum_out}; then → WAIT_ACK.
  - WAIT_ACK → WAIT_DONE when tx_busy=1.
  - WAIT_DONE → IDLE when tx_busy=0.
  - tx_data holds stable from SEND until the next SEND.
  - tx_start is 0 in all states other than SEND.
- Latency, idle TX: press event fires DEBOUNCE_CYCLES+2 edges after the first edge sampling raw low. Capture happens on that edge, sum_out the next edge, and tx_start is high the cycle after pending is set.
- send_en=0 keeps the FSM in IDLE with pending retained. De-asserting send_en outside IDLE does not abort the transfer in progress.

Test Plan:
1. Reset, no stimulus → tx_start=0, tx_data=0x00, sum_out=0, a_valid=b_valid=0 for 50 cycles.
2. data_input=3, save_a_n low 8 cycles then high; data_input=5, save_b_n low 8 cycles → a_valid=b_valid=1, sum_out=8, single tx_start pulse with tx_data=0x08. Model tx_busy high 10 cycles after the strobe; no further strobe.
3. save_a_n toggling low 2 / high 1 for 30 cycles, data_input=6 → no capture; a_valid stays 0; tx_start never asserted.
4. tx_busy held 1 when operands A=7, B=7 complete → no tx_start until busy falls; then exactly one pulse with tx_data=0x0E.
5. During WAIT_DONE of a transfer of 3+5, press A with data_input=7 → after busy falls, a second pulse with tx_data=0x0C; exactly two strobes total.
6. Assert reset while in WAIT_ACK, release, hold tx_busy 0 for 40 cycles → tx_start stays 0; a_valid=b_valid=0; sum_out=0.

Source files
------------

// File: rtl/sum_latch_ctrl.sv
// SumLatch operand capture and UART send-request controller: debounces the two
// save buttons, latches A/B from the switches, and hands A+B to the transmitter.
module sum_latch_ctrl #(
  parameter int DATA_W          = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              send_en,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [DATA_W:0]   sum_out,
  output logic              a_valid,
  output logic              b_valid
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  // Button vectors: bit 0 is save A, bit 1 is save B; level 1 means released.
  logic [1:0]        btn_sync1_q, btn_sync2_q;
  logic [1:0]        btn_state_q, btn_state_d;
  logic [CNT_W-1:0]  deb_cnt_q [2];
  logic [CNT_W-1:0]  deb_cnt_d [2];
  logic [1:0]        press_q, press_d;

  logic [DATA_W-1:0] data_sync1_q, data_sync2_q;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              a_valid_q, a_valid_d;
  logic              b_valid_q, b_valid_d;
  logic              cap_q, cap_d;
  logic [DATA_W:0]   sum_q, sum_d;
  logic              pending_q, pending_d;
  logic              go_send;

  state_e            state_q;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync1_q  <= 2'b11;
      btn_sync2_q  <= 2'b11;
      data_sync1_q <= '0;
      data_sync2_q <= '0;
    end else begin
      btn_sync1_q  <= {save_b_n, save_a_n};
      btn_sync2_q  <= btn_sync1_q;
      data_sync1_q <= data_input;
      data_sync2_q <= data_sync1_q;
    end
  end

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    btn_state_d = btn_state_q;
    press_d     = '0;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (btn_sync2_q[i] != btn_state_q[i]) begin
        if (deb_cnt_q[i] == CNT_LAST) begin
          btn_state_d[i] = btn_sync2_q[i];
          press_d[i]     = ~btn_sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_state_q <= 2'b11;
      press_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      btn_state_q <= btn_state_d;
      press_q     <= press_d;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  always_comb begin
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    if (press_q[0]) begin
      op_a_d    = data_sync2_q;
      a_valid_d = 1'b1;
    end
    if (press_q[1]) begin
      op_b_d    = data_sync2_q;
      b_valid_d = 1'b1;
    end
    cap_d = |press_q;

    sum_d = sum_q;
    if (cap_q) begin
      sum_d = {1'b0, op_a_q} + {1'b0, op_b_q};
    end

    go_send = (state_q == IDLE) && pending_q && send_en && !tx_busy;

    // Set wins over clear: a sum landing on the same edge as SEND entry was
    // not the one captured into tx_data, so it still needs its own transfer.
    pending_d = pending_q;
    if (go_send) begin
      pending_d = 1'b0;
    end
    if (cap_q && a_valid_q && b_valid_q) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      cap_q     <= 1'b0;
      sum_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      cap_q     <= cap_d;
      sum_q     <= sum_d;
      pending_q <= pending_d;
    end
  end

  // Strobe and byte are registered with the state so they change together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_send) begin
            state_q    <= SEND;
            tx_start_q <= 1'b1;
            tx_data_q  <= 8'(sum_q);
          end
        end
        SEND:      state_q <= WAIT_ACK;
        WAIT_ACK:  if (tx_busy)  state_q <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign sum_out  = sum_q;
  assign a_valid  = a_valid_q;
  assign b_valid  = b_valid_q;

endmodule

// File: tb/tb_sum_latch_ctrl.sv
// Directed bench for sum_latch_ctrl: table-driven operand pairs plus
// hand-written sequences for bounce, busy stalls, re-capture and reset abort.
module tb_sum_latch_ctrl;

  localparam int DATA_W = 3;
  localparam int DEB    = 4;

  logic              clk        = 1'b0;
  logic              reset      = 1'b1;
  logic              save_a_n   = 1'b1;
  logic              save_b_n   = 1'b1;
  logic [DATA_W-1:0] data_input = '0;
  logic              send_en    = 1'b1;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [DATA_W:0]   sum_out;
  logic              a_valid;
  logic              b_valid;

  int         checks     = 0;
  int         errors     = 0;
  int         strobe_cnt = 0;
  logic [7:0] last_data  = '0;
  bit         auto_busy  = 1'b1;
  bit         force_busy = 1'b0;
  logic       model_busy = 1'b0;
  int         busy_left  = 0;

  assign tx_busy = force_busy | model_busy;

  sum_latch_ctrl #(
    .DATA_W         (DATA_W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .save_a_n  (save_a_n),
    .save_b_n  (save_b_n),
    .data_input(data_input),
    .send_en   (send_en),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .sum_out   (sum_out),
    .a_valid   (a_valid),
    .b_valid   (b_valid)
  );

  always #5 clk = ~clk;

  // UART stand-in: counts strobes and reports busy for 10 cycles after each.
  initial forever begin
    @(posedge clk);
    #2;
    if (reset) begin
      busy_left  = 0;
      model_busy = 1'b0;
    end else begin
      if (tx_start === 1'b1) begin
        strobe_cnt++;
        last_data = tx_data;
        if (auto_busy) busy_left = 10;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      model_busy = (busy_left > 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    save_a_n   = 1'b1;
    save_b_n   = 1'b1;
    force_busy = 1'b0;
    auto_busy  = 1'b1;
    send_en    = 1'b1;
    cycles(3);
    reset      = 1'b0;
    strobe_cnt = 0;
    last_data  = '0;
    cycles(2);
  endtask

  task automatic press(input bit is_b, input logic [DATA_W-1:0] val, input int low_cycles);
    data_input = val;
    cycles(3);
    if (is_b) save_b_n = 1'b0;
    else      save_a_n = 1'b0;
    cycles(low_cycles);
    save_a_n = 1'b1;
    save_b_n = 1'b1;
    cycles(DEB + 4);
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (strobe_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_strobe_seen"}, 32'(strobe_cnt >= n), 32'd1);
  endtask

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    int                hold_b;
    logic [DATA_W:0]   sum;
    logic [7:0]        byte_exp;
  } vec_t;

  vec_t vecs [6];
  bit   bad;
  int   n;

  initial begin
    vecs[0] = '{3'd3, 3'd5, 8,  4'd8,  8'h08};
    vecs[1] = '{3'd0, 3'd0, 8,  4'd0,  8'h00};
    vecs[2] = '{3'd7, 3'd7, 8,  4'd14, 8'h0E};
    vecs[3] = '{3'd1, 3'd6, 4,  4'd7,  8'h07};
    vecs[4] = '{3'd7, 3'd0, 8,  4'd7,  8'h07};
    vecs[5] = '{3'd4, 3'd4, 30, 4'd8,  8'h08};

    // Reset state and a quiet idle period.
    do_reset();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_sum_out",  32'(sum_out),  32'd0);
    check("rst_a_valid",  32'(a_valid),  32'd0);
    check("rst_b_valid",  32'(b_valid),  32'd0);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || tx_data !== 8'h00 || sum_out !== '0 ||
          a_valid !== 1'b0 || b_valid !== 1'b0) bad = 1'b1;
    end
    check("idle_50_quiet", 32'(bad), 32'd0);

    // Operand pairs, one complete transfer each.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      press(1'b0, vecs[i].a, 8);
      check($sformatf("v%0d_a_only_valid", i), 32'({a_valid, b_valid}), 32'b10);
      cycles(4);
      check($sformatf("v%0d_a_only_no_strobe", i), 32'(strobe_cnt), 32'd0);
      press(1'b1, vecs[i].b, vecs[i].hold_b);
      wait_strobes(1, 40, $sformatf("v%0d", i));
      cycles(20);
      check($sformatf("v%0d_sum_out", i),   32'(sum_out),   32'(vecs[i].sum));
      check($sformatf("v%0d_tx_data", i),   32'(tx_data),   32'(vecs[i].byte_exp));
      check($sformatf("v%0d_strobe_data", i), 32'(last_data), 32'(vecs[i].byte_exp));
      check($sformatf("v%0d_strobes", i),   32'(strobe_cnt), 32'd1);
      check($sformatf("v%0d_valids", i),    32'({a_valid, b_valid}), 32'b11);
    end

    // Idle-TX latency from first low sample to strobe.
    do_reset();
    press(1'b0, 3'd3, 8);
    data_input = 3'd5;
    cycles(3);
    save_b_n = 1'b0;
    @(posedge clk);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (tx_start === 1'b1) break;
      n++;
    end
    check("latency_edges", 32'(n), 32'(DEB + 4));
    check("latency_sum",   32'(sum_out), 32'd8);
    cycles(6);
    save_b_n = 1'b1;
    cycles(30);
    check("latency_strobes", 32'(strobe_cnt), 32'd1);

    // Bounces shorter than the debounce window never capture.
    do_reset();
    data_input = 3'd6;
    cycles(3);
    repeat (10) begin
      save_a_n = 1'b0;
      cycles(2);
      save_a_n = 1'b1;
      cycles(1);
    end
    cycles(12);
    check("bounce_a_valid", 32'(a_valid), 32'd0);
    save_a_n = 1'b0;
    cycles(DEB - 1);
    save_a_n = 1'b1;
    cycles(12);
    check("short_press_a_valid", 32'(a_valid), 32'd0);
    check("bounce_strobes",      32'(strobe_cnt), 32'd0);
    press(1'b0, 3'd6, DEB);
    check("min_press_a_valid", 32'(a_valid), 32'd1);

    // Busy already high when operands complete.
    do_reset();
    force_busy = 1'b1;
    press(1'b0, 3'd7, 8);
    press(1'b1, 3'd7, 8);
    cycles(30);
    check("busy_hold_no_strobe", 32'(strobe_cnt), 32'd0);
    check("busy_hold_sum",       32'(sum_out),    32'd14);
    force_busy = 1'b0;
    wait_strobes(1, 20, "busy_release");
    cycles(25);
    check("busy_release_strobes", 32'(strobe_cnt), 32'd1);
    check("busy_release_data",    32'(last_data),  32'h0E);

    // New capture while a transfer is still in progress.
    do_reset();
    press(1'b0, 3'd3, 8);
    press(1'b1, 3'd5, 8);
    force_busy = 1'b1;
    check("recap_first_strobe", 32'(strobe_cnt), 32'd1);
    press(1'b0, 3'd7, 8);
    cycles(5);
    check("recap_held_strobes", 32'(strobe_cnt), 32'd1);
    check("recap_tx_data_held", 32'(tx_data),    32'h08);
    check("recap_new_sum",      32'(sum_out),    32'd12);
    force_busy = 1'b0;
    wait_strobes(2, 40, "recap_second");
    cycles(25);
    check("recap_strobes",     32'(strobe_cnt), 32'd2);
    check("recap_second_data", 32'(last_data),  32'h0C);

    // send_en low holds the request in IDLE.
    do_reset();
    send_en = 1'b0;
    press(1'b0, 3'd2, 8);
    press(1'b1, 3'd3, 8);
    cycles(30);
    check("send_en_hold_strobes", 32'(strobe_cnt), 32'd0);
    send_en = 1'b1;
    wait_strobes(1, 10, "send_en_release");
    cycles(20);
    check("send_en_release_data", 32'(last_data), 32'h05);

    // Reset while waiting for the TX acknowledge aborts everything.
    do_reset();
    auto_busy = 1'b0;
    press(1'b0, 3'd3, 8);
    press(1'b1, 3'd5, 8);
    check("abort_pre_strobes", 32'(strobe_cnt), 32'd1);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    strobe_cnt = 0;
    cycles(40);
    check("abort_strobes", 32'(strobe_cnt), 32'd0);
    check("abort_valids",  32'({a_valid, b_valid}), 32'b00);
    check("abort_sum",     32'(sum_out), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);

    // Reset while a request is pending but held off by send_en.
    do_reset();
    send_en = 1'b0;
    press(1'b0, 3'd1, 8);
    press(1'b1, 3'd1, 8);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    send_en = 1'b1;
    strobe_cnt = 0;
    cycles(40);
    check("pending_abort_strobes", 32'(strobe_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
